reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the ProtoCore 8-bit datapath: 16 entries x 8 bits.
- Two independent combinational read ports (A, B) feed the ALU operand paths.
- One synchronous write port is driven by the writeback stage.
- All entries are cleared by an asynchronous reset.

Parameters:
- DATA_W, 8, width of each register and of the wd, read_a and read_b ports.
- ADDR_W, 4, address width; depth = 2**ADDR_W (16 entries).

Ports:
- clk  input  1  system clock; the write occurs on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); clears all entries.
- ra  input  ADDR_W  read port A address.
- rb  input  ADDR_W  read port B address.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- we  input  1  write enable, active-high, sampled on the rising edge of clk.
- read_a  output  DATA_W  contents of entry ra (combinational).
- read_b  output  DATA_W  contents of entry rb (combinational).

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Entry 0 is an ordinary writable register, not hardwired to zero.
- Reset:
  - While rst=0, every entry is forced to 0 immediately, with no clock required; read_a and read_b therefore read 0.
  - Writes are ignored while rst=0.
  - Reset asserted mid-operation overrides any write in the same cycle.
  - Deassertion is taken at the next rising edge; the first write can land on the first rising edge with rst=1.
- Write:
  - On a rising edge of clk with rst=1 and we=1, entry[wa] <= wd.
  - With we=0 no entry changes, whatever wa and wd are.
  - Exactly one entry is written per edge; all other entries hold.
- Read:
  - read_a = entry[ra] and read_b = entry[rb], purely combinational, with no clock latency.
  - Address changes are reflected within the same cycle.
  - ra == rb is legal; both ports return the same value.
- Write/read collision:
  - When we=1 and wa equals ra or rb, the read port shows the old value until the rising edge.
  - The new value is visible immediately after that edge.
  - There is no write-to-read bypass.
- Latency:
  - Write to readable: 1 clock edge.
  - Address to data: 0 cycles (combinational).
- No X-propagation from unwritten entries: every entry is defined (0) after reset.
- Addresses are full-width; every value 0..2**ADDR_W-1 is valid, so there are no out-of-range cases.

Test Plan:
- Reset: assert rst=0 after arbitrary writes, sampling without any clock edge -> read_a and read_b go to 0x00 immediately; after release, every entry 0..15 reads 0x00.
- Fill and readback: write entry i = i*0x11 for i=0..15 with we=1 on consecutive edges; then sweep ra=i, rb=15-i -> read_a = i*0x11 and read_b = (15-i)*0x11 on every address (e.g. ra=2 gives 0x22 and rb=13 gives 0xDD in the same cycle).
- Overwrite: we=1, wa=3, wd=0xAA for one edge, then ra=rb=3 -> both ports read 0xAA; entries 2 and 4 still read 0x22 and 0x44.
- Write-enable gating: we=0, wa=5, wd=0x11 across a rising edge, after entry 5 was first written to 0x77 -> ra=5 still reads 0x77.
- Collision timing: ra=7 holding 0x77, then we=1, wa=7, wd=0x5C -> read_a=0x77 before the edge and 0x5C after it.
- Reset mid-write: we=1, wa=9, wd=0xF0 with rst=0 across the edge -> entry 9 reads 0x00 after rst returns to 1.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file: general-purpose register file for the ProtoCore 8-bit datapath.
//
// 2**ADDR_W entries of DATA_W bits, two combinational read ports and one
// synchronous write port. Every entry is cleared asynchronously while rst is
// low.
//
// Ports:
//   clk     in   system clock, write lands on the rising edge
//   rst     in   asynchronous active-low reset, clears every entry
//   ra, rb  in   read port A / B address
//   wa      in   write address
//   wd      in   write data
//   we      in   write enable (active high, sampled on rising clk)
//   read_a  out  entry[ra], combinational
//   read_b  out  entry[rb], combinational
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;

    // One register per entry, each with its own decoded write strobe so that
    // exactly one entry is touched per edge and the others simply hold.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic wr_hit;
        assign wr_hit = we && (wa == ADDR_W'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                regs[i] <= '0;
            else if (wr_hit)
                regs[i] <= wd;
        end
    end

    // Plain array reads: no write-to-read bypass, a same-cycle write shows up
    // only after the edge.
    assign read_a = regs[ra];
    assign read_b = regs[rb];

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra, rb, wa;
    logic [7:0] wd;
    logic       we;
    logic [7:0] read_a, read_b;

    int total = 0;
    int bad   = 0;

    // Reference storage: what each entry should hold.
    logic [7:0] mdl [16];

    typedef struct {
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [16];

    reg_file #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .ra    (ra),
        .rb    (rb),
        .wa    (wa),
        .wd    (wd),
        .we    (we),
        .read_a(read_a),
        .read_b(read_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        ra = a; rb = b;
        #1;
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = 4'd0; rb = 4'd15;
        clear_mdl();

        // Reset state, no clock edge yet.
        #1;
        check("reset_a", read_a, 8'h00);
        check("reset_b", read_b, 8'h00);
        @(negedge clk); rst = 1'b1;

        // Asynchronous reset after arbitrary writes.
        wr(4'd1, 8'h3C);
        wr(4'd14, 8'hC3);
        rd(4'd1, 4'd14);
        check("pre_rst_a", read_a, 8'h3C);
        check("pre_rst_b", read_b, 8'hC3);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_rst_a", read_a, 8'h00);
        check("async_rst_b", read_b, 8'h00);
        clear_mdl();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i));
            check("post_rst_sweep", read_a, 8'h00);
        end

        // Fill and table-driven readback.
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 8'h11));
        for (int i = 0; i < 16; i++)
            vecs[i] = '{ra: 4'(i), rb: 4'(15 - i),
                        exp_a: 8'(i * 8'h11), exp_b: 8'(((15 - i) * 8'h11))};
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd(vecs[i].ra, vecs[i].rb);
            check("fill_a", read_a, vecs[i].exp_a);
            check("fill_b", read_b, vecs[i].exp_b);
        end

        // Overwrite one entry, neighbours hold.
        wr(4'd3, 8'hAA);
        rd(4'd3, 4'd3);
        check("ovr_a", read_a, 8'hAA);
        check("ovr_b", read_b, 8'hAA);
        rd(4'd2, 4'd4);
        check("ovr_nb2", read_a, 8'h22);
        check("ovr_nb4", read_b, 8'h44);

        // Write-enable gating.
        wr(4'd5, 8'h77);
        @(negedge clk);
        we = 1'b0; wa = 4'd5; wd = 8'h11;
        @(posedge clk); #1;
        rd(4'd5, 4'd5);
        check("we_gate", read_a, 8'h77);

        // Collision: old value before the edge, new value after.
        wr(4'd7, 8'h77);
        @(negedge clk);
        rd(4'd7, 4'd7);
        we = 1'b1; wa = 4'd7; wd = 8'h5C;
        #1;
        check("coll_before", read_a, 8'h77);
        @(posedge clk); #1;
        we = 1'b0;
        mdl[7] = 8'h5C;
        check("coll_after", read_a, 8'h5C);

        // Reset held across an enabled write edge.
        @(negedge clk);
        we = 1'b1; wa = 4'd9; wd = 8'hF0; rst = 1'b0;
        @(posedge clk); #1;
        we = 1'b0;
        clear_mdl();
        @(negedge clk); rst = 1'b1;
        rd(4'd9, 4'd0);
        check("rst_mid_write", read_a, 8'h00);
        // First write right after release lands.
        wr(4'd9, 8'h9A);
        rd(4'd9, 4'd9);
        check("post_release_wr", read_b, 8'h9A);

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            wa = 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            we = ($urandom_range(0, 2) != 0);
            #1;
            check("rnd_a", read_a, mdl[ra]);
            check("rnd_b", read_b, mdl[rb]);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b0;
                #1;
                check("rnd_rst_a", read_a, 8'h00);
                check("rnd_rst_b", read_b, 8'h00);
                clear_mdl();
                @(posedge clk); #1;
                rst = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (we) mdl[wa] = wd;
            end
        end
        we = 1'b0;

        // Final full sweep.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i));
            check("final_a", read_a, mdl[i]);
            check("final_b", read_b, mdl[15 - i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
